// File: rtl/spi_pkg.sv
// Shared SPI definitions for master and slave.
// State encoding plus the clock mode constants.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// RST_VAL is the idle level the chain resets to.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled SCLK/MOSI/cs, MSB-first frames,
// back-to-back capable, with frame-abort detection.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  cs,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_datain,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_dataout,
    output logic                  rx_valid,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic sclk_s, mosi_s, cs_s;
    logic sclk_d, cs_d;
    logic sclk_lvl, sclk_lvl_d;
    logic sclk_rise, sclk_fall, cs_fall;

    spi_state_t            state;
    logic [DATA_WIDTH-2:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [CNT_W-1:0]      cnt;
    logic                  seen_rise;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(cs), .q(cs_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    // Sampling edge is the rising edge of SCLK folded by the mode bits.
    assign sclk_lvl   = sclk_s ^ (CPOL ^ CPHA);
    assign sclk_lvl_d = sclk_d ^ (CPOL ^ CPHA);
    assign sclk_rise  = sclk_lvl & ~sclk_lvl_d;
    assign sclk_fall  = ~sclk_lvl & sclk_lvl_d;
    assign cs_fall    = ~cs_s & cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            MISO        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            rx_dataout  <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cnt         <= '0;
            seen_rise   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    MISO    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    if (cs_fall) begin
                        state     <= SHIFT;
                        tx_sr     <= tx_datain[DATA_WIDTH-2:0];
                        MISO      <= tx_datain[DATA_WIDTH-1];
                        miso_oe   <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(DATA_WIDTH - 1);
                        seen_rise <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr     <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
                        cnt       <= cnt - 1'b1;
                        seen_rise <= 1'b1;
                        if (cnt == '0) begin
                            state <= DONE;
                            if (cs_s) begin
                                miso_oe <= 1'b0;
                                MISO    <= 1'b0;
                            end
                        end
                    end else if (cs_s) begin
                        // Deselect with no bits taken is a clean end, not an error.
                        state       <= IDLE;
                        frame_error <= seen_rise;
                        busy        <= 1'b0;
                        miso_oe     <= 1'b0;
                        MISO        <= 1'b0;
                    end else if (sclk_fall && seen_rise) begin
                        MISO  <= tx_sr[DATA_WIDTH-2];
                        tx_sr <= tx_sr << 1;
                    end
                end
                DONE: begin
                    rx_dataout <= rx_sr;
                    rx_valid   <= 1'b1;
                    if (!cs_s) begin
                        state     <= SHIFT;
                        tx_sr     <= tx_datain[DATA_WIDTH-2:0];
                        MISO      <= tx_datain[DATA_WIDTH-1];
                        miso_oe   <= 1'b1;
                        cnt       <= CNT_W'(DATA_WIDTH - 1);
                        seen_rise <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        MISO    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 bit-banged master
// drives frames and checks hand-computed results.
module tb_spi_slave;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCLK = 1'b0;
    logic       cs = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       miso_oe;
    logic [7:0] tx_datain = 8'h00;
    logic       busy;
    logic [7:0] rx_dataout;
    logic       rx_valid;
    logic       frame_error;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .SCLK(SCLK),
        .cs(cs),
        .MOSI(MOSI),
        .MISO(MISO),
        .miso_oe(miso_oe),
        .tx_datain(tx_datain),
        .busy(busy),
        .rx_dataout(rx_dataout),
        .rx_valid(rx_valid),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rx_prev = 8'h00;
    logic [7:0] rx_last = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt  = rv_cnt + 1;
            rx_prev = rx_last;
            rx_last = rx_dataout;
        end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (rx_valid && frame_error) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] m_tx, input int nbits,
                        input bit end_cs, input logic [7:0] tx_next,
                        output logic [7:0] m_rx,
                        output logic mid_busy, output logic mid_oe);
        m_rx     = 8'h00;
        mid_busy = 1'b0;
        mid_oe   = 1'b0;
        cs       = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = m_tx[7-i];
            #HALF;
            SCLK = 1'b1;
            m_rx = {m_rx[6:0], MISO};
            if (i == 0) begin
                mid_busy  = busy;
                mid_oe    = miso_oe;
                tx_datain = tx_next;
            end
            #HALF;
            SCLK = 1'b0;
        end
        if (end_cs) begin
            #HALF;
            cs = 1'b1;
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] r1, r2;
    logic       mb, mo;
    logic       acc;
    int         rv0, fe0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_miso", MISO, 1'b0);
        chk("rst_rx", rx_dataout, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_ferr", frame_error, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single frame
        rv0 = rv_cnt; fe0 = fe_cnt;
        tx_datain = 8'h3C;
        xfer(8'hA5, 8, 1'b1, 8'h3C, r1, mb, mo);
        chk("f1_busy_mid", mb, 1'b1);
        chk("f1_oe_mid", mo, 1'b1);
        chk("f1_rx", rx_dataout, 8'hA5);
        chk("f1_master", r1, 8'h3C);
        chk("f1_nvalid", rv_cnt - rv0, 1);
        chk("f1_nferr", fe_cnt - fe0, 0);
        chk("f1_busy_end", busy, 1'b0);
        chk("f1_oe_end", miso_oe, 1'b0);

        // back-to-back frames with cs held low
        @(negedge clk);
        rv0 = rv_cnt; fe0 = fe_cnt;
        tx_datain = 8'h80;
        xfer(8'h01, 8, 1'b0, 8'h7E, r1, mb, mo);
        xfer(8'hFF, 8, 1'b1, 8'h7E, r2, mb, mo);
        chk("b2b_nvalid", rv_cnt - rv0, 2);
        chk("b2b_rx0", rx_prev, 8'h01);
        chk("b2b_rx1", rx_last, 8'hFF);
        chk("b2b_m0", r1, 8'h80);
        chk("b2b_m1", r2, 8'h7E);
        chk("b2b_nferr", fe_cnt - fe0, 0);

        // abort after 3 bits
        @(negedge clk);
        rv0 = rv_cnt; fe0 = fe_cnt;
        xfer(8'hE0, 3, 1'b1, 8'h7E, r1, mb, mo);
        chk("abort_nferr", fe_cnt - fe0, 1);
        chk("abort_nvalid", rv_cnt - rv0, 0);
        chk("abort_rx", rx_dataout, 8'hFF);
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", miso_oe, 1'b0);

        // tx_datain changed mid-frame
        @(negedge clk);
        tx_datain = 8'h55;
        xfer(8'h12, 8, 1'b1, 8'hAA, r1, mb, mo);
        chk("txhold_master", r1, 8'h55);
        chk("txhold_rx", rx_dataout, 8'h12);

        // reset after 4 bits
        @(negedge clk);
        rv0 = rv_cnt; fe0 = fe_cnt;
        tx_datain = 8'h00;
        xfer(8'h5A, 4, 1'b0, 8'h00, r1, mb, mo);
        #HALF;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_oe", miso_oe, 1'b0);
        chk("mrst_miso", MISO, 1'b0);
        chk("mrst_rx", rx_dataout, 8'h00);
        cs = 1'b1;
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        tx_datain = 8'h96;
        xfer(8'hC3, 8, 1'b1, 8'h96, r1, mb, mo);
        chk("mrst_after_rx", rx_dataout, 8'hC3);
        chk("mrst_after_m", r1, 8'h96);
        chk("mrst_nvalid", rv_cnt - rv0, 1);
        chk("mrst_nferr", fe_cnt - fe0, 0);

        // SCLK activity while deselected
        @(negedge clk);
        rv0 = rv_cnt; fe0 = fe_cnt;
        acc = 1'b0;
        for (int i = 0; i < 16; i++) begin
            SCLK = ~SCLK;
            MOSI = i[0];
            #HALF;
            acc = acc | busy | miso_oe;
        end
        chk("desel_busy_oe", acc, 1'b0);
        chk("desel_nvalid", rv_cnt - rv0, 0);
        chk("desel_nferr", fe_cnt - fe0, 0);

        chk("excl_pulses", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
